pueo_trig_capture: RTL and testbench

//  Sits directly downstream of the L2 trigger stage.
//  - Consumes its trigger pulse and the four delay-aligned TURFIO metadata words.
//  - Numbers each trigger and buffers trigger number + metadata in a small FIFO.
//  - Presents buffered records to the event builder on a valid/ready stream.
//  - Generates the holdoff signal fed back to L2: per-trigger holdoff, plus back-pressure when the FIFO is nearly full.

---
 rtl/pueo_trig_capture_if.sv | 56 +++++
 rtl/pueo_trig_capture.sv | 239 +++++++++++++++++++++++
 tb/tb_pueo_trig_capture.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/pueo_trig_capture_if.sv
// -----------------------------------------------------------------------------
// pueo_trig_capture_if
//   Output record stream from the trigger capture block to the event builder.
//   A record is transferred on a cycle where m_valid_o && m_ready_i.
//
//   Signals:
//     m_valid_o     head record valid (driven by master)
//     m_ready_i     record accepted (driven by slave)
//     m_trig_num_o  32-bit trigger number of the head record
//     m_meta_o      256-bit {tio3,tio2,tio1,tio0} metadata of the head record
//     m_time_o      48-bit capture timestamp, present only when
//                   PUEO_TRIG_CAPTURE_TIMESTAMP_EN is defined
//
//   Modports: master (capture block side), slave (event builder side).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

interface pueo_trig_capture_if;
  logic         m_valid_o;
  logic         m_ready_i;
  logic [31:0]  m_trig_num_o;
  logic [255:0] m_meta_o;
`ifdef PUEO_TRIG_CAPTURE_TIMESTAMP_EN
  logic [47:0]  m_time_o;

  modport master (
    output m_valid_o,
    output m_trig_num_o,
    output m_meta_o,
    output m_time_o,
    input  m_ready_i
  );

  modport slave (
    input  m_valid_o,
    input  m_trig_num_o,
    input  m_meta_o,
    input  m_time_o,
    output m_ready_i
  );
`else
  modport master (
    output m_valid_o,
    output m_trig_num_o,
    output m_meta_o,
    input  m_ready_i
  );

  modport slave (
    input  m_valid_o,
    input  m_trig_num_o,
    input  m_meta_o,
    output m_ready_i
  );
`endif
endinterface

// File: rtl/pueo_trig_capture.sv
// -----------------------------------------------------------------------------
// pueo_trig_capture
//   Sits downstream of the L2 trigger stage. Numbers every trigger, buffers
//   {trigger number, TURFIO metadata} in a small FIFO, presents the buffered
//   records on a valid/ready stream, and generates the holdoff fed back to L2
//   (per-trigger holdoff plus back-pressure when the FIFO is nearly full).
//
//   Optional feature macro: PUEO_TRIG_CAPTURE_TIMESTAMP_EN
//     When defined, a 48-bit free-running clk_i counter is sampled in the
//     trigger cycle, stored with the record and presented on m_if.m_time_o.
//
//   Parameters:
//     DEPTH_LOG2   FIFO depth = 2**DEPTH_LOG2 records (2..6)
//     AFULL_SLACK  holdoff forced while free entries <= AFULL_SLACK
//
//   Ports:
//     clk_i          system clock
//     rst_n_i        asynchronous active-low reset
//     ce_i           clock enable for holdoff counting
//     trig_i         trigger pulse from L2 (max one cycle wide)
//     tio0..3_meta_i 64-bit TURFIO metadata aligned with trig_i
//     holdoff_len_i  per-trigger holdoff length in ce_i cycles
//     clear_i        synchronous clear of trig/drop counters and overflow flag
//     holdoff_o      registered holdoff to L2
//     m_if           output record stream (master modport)
//     trig_count_o   total triggers seen, including dropped ones
//     drop_count_o   triggers dropped on a full FIFO (saturating)
//     overflow_o     sticky drop indicator
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module pueo_trig_capture #(
  parameter int DEPTH_LOG2  = 4,
  parameter int AFULL_SLACK = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       ce_i,
  input  logic                       trig_i,
  input  logic [63:0]                tio0_meta_i,
  input  logic [63:0]                tio1_meta_i,
  input  logic [63:0]                tio2_meta_i,
  input  logic [63:0]                tio3_meta_i,
  input  logic [15:0]                holdoff_len_i,
  input  logic                       clear_i,
  output logic                       holdoff_o,
  pueo_trig_capture_if.master        m_if,
  output logic [31:0]                trig_count_o,
  output logic [15:0]                drop_count_o,
  output logic                       overflow_o
);

  localparam int PW    = DEPTH_LOG2 + 1;
  localparam int DEPTH = 1 << DEPTH_LOG2;
`ifdef PUEO_TRIG_CAPTURE_TIMESTAMP_EN
  localparam int RW    = 48 + 32 + 256;
`else
  localparam int RW    = 32 + 256;
`endif
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
  localparam logic [PW-1:0] SLACK_P = PW'(AFULL_SLACK);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [31:0]   r_trig_count;
  logic [15:0]   r_drop_count;
  logic          r_overflow;
  state_t        r_state;
  logic [15:0]   r_cnt;
  logic          r_holdoff;
  logic [RW-1:0] r_mem [DEPTH];
`ifdef PUEO_TRIG_CAPTURE_TIMESTAMP_EN
  logic [47:0]   r_time;
`endif

  // ---------------------------------------------------------------------------
  // Wires
  // ---------------------------------------------------------------------------
  logic [63:0]   w_tio [4];
  logic [255:0]  w_meta;
  logic [31:0]   w_trig_num;
  logic [RW-1:0] w_rec;
  logic [RW-1:0] w_rd_rec;
  logic [PW-1:0] w_occ;
  logic          w_full;
  logic          w_valid;
  logic          w_push;
  logic          w_pop;
  logic [PW-1:0] w_occ_next;
  logic [PW-1:0] w_free_next;
  logic [15:0]   w_load;
  state_t        w_state_next;
  logic [15:0]   w_cnt_next;

  assign w_tio[0] = tio0_meta_i;
  assign w_tio[1] = tio1_meta_i;
  assign w_tio[2] = tio2_meta_i;
  assign w_tio[3] = tio3_meta_i;

  // Metadata packed as {tio3,tio2,tio1,tio0}
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_meta
      assign w_meta[gi*64 +: 64] = w_tio[gi];
    end
  endgenerate

  // A trigger coincident with clear is numbered as the first after the clear.
  assign w_trig_num = clear_i ? 32'd0 : r_trig_count;

`ifdef PUEO_TRIG_CAPTURE_TIMESTAMP_EN
  assign w_rec = {r_time, w_trig_num, w_meta};
`else
  assign w_rec = {w_trig_num, w_meta};
`endif

  // ---------------------------------------------------------------------------
  // FIFO control. Full is judged on the registered occupancy, so a push onto
  // a full FIFO is dropped even when a pop happens in the same cycle.
  // ---------------------------------------------------------------------------
  assign w_occ       = r_wr_ptr - r_rd_ptr;
  assign w_full      = (w_occ == DEPTH_P);
  assign w_valid     = (w_occ != '0);
  assign w_push      = trig_i && !w_full;
  assign w_pop       = w_valid && m_if.m_ready_i;
  assign w_occ_next  = (r_wr_ptr + PW'(w_push)) - (r_rd_ptr + PW'(w_pop));
  assign w_free_next = DEPTH_P - w_occ_next;

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wr_ptr[DEPTH_LOG2-1:0]] <= w_rec;
    end
  end

  assign w_rd_rec = r_mem[r_rd_ptr[DEPTH_LOG2-1:0]];

  // Data is forced to zero while nothing is queued so outputs read 0 in reset.
  assign m_if.m_valid_o    = w_valid;
  assign m_if.m_trig_num_o = w_valid ? w_rd_rec[287:256] : 32'd0;
  assign m_if.m_meta_o     = w_valid ? w_rd_rec[255:0]   : 256'd0;
`ifdef PUEO_TRIG_CAPTURE_TIMESTAMP_EN
  assign m_if.m_time_o     = w_valid ? w_rd_rec[335:288] : 48'd0;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
    end
  end

`ifdef PUEO_TRIG_CAPTURE_TIMESTAMP_EN
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) r_time <= '0;
    else          r_time <= r_time + 48'd1;
  end
`endif

  // ---------------------------------------------------------------------------
  // Statistics counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_trig_count <= '0;
      r_drop_count <= '0;
      r_overflow   <= 1'b0;
    end else if (clear_i) begin
      r_trig_count <= trig_i ? 32'd1 : 32'd0;
      r_drop_count <= '0;
      r_overflow   <= 1'b0;
    end else if (trig_i) begin
      r_trig_count <= r_trig_count + 32'd1;
      if (w_full) begin
        r_overflow <= 1'b1;
        if (r_drop_count != 16'hFFFF) r_drop_count <= r_drop_count + 16'd1;
      end
    end
  end

  assign trig_count_o = r_trig_count;
  assign drop_count_o = r_drop_count;
  assign overflow_o   = r_overflow;

  // ---------------------------------------------------------------------------
  // Holdoff FSM. A zero length still yields one ce_i cycle of holdoff.
  // ---------------------------------------------------------------------------
  assign w_load = (holdoff_len_i == 16'd0) ? 16'd1 : holdoff_len_i;

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (trig_i) begin
          w_state_next = S_HOLD;
          w_cnt_next   = w_load;
        end
      end
      S_HOLD: begin
        if (trig_i) begin
          w_cnt_next = w_load;
        end else if (ce_i) begin
          if (r_cnt == 16'd1) w_state_next = S_IDLE;
          else                w_cnt_next   = r_cnt - 16'd1;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_holdoff <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      // Registered so it lines up with the state and occupancy it reflects.
      r_holdoff <= (w_state_next == S_HOLD) || (w_free_next <= SLACK_P);
    end
  end

  assign holdoff_o = r_holdoff;

endmodule

// File: tb/tb_pueo_trig_capture.sv
`timescale 1ns/1ps

module tb_pueo_trig_capture;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ce;
  logic        trig;
  logic [63:0] tio0, tio1, tio2, tio3;
  logic [15:0] hlen;
  logic        clear;
  logic        holdoff;
  logic [31:0] trig_count;
  logic [15:0] drop_count;
  logic        overflow;

  always #5 clk = ~clk;

  pueo_trig_capture_if m_if();

  pueo_trig_capture #(.DEPTH_LOG2(4), .AFULL_SLACK(2)) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .ce_i          (ce),
    .trig_i        (trig),
    .tio0_meta_i   (tio0),
    .tio1_meta_i   (tio1),
    .tio2_meta_i   (tio2),
    .tio3_meta_i   (tio3),
    .holdoff_len_i (hlen),
    .clear_i       (clear),
    .holdoff_o     (holdoff),
    .m_if          (m_if),
    .trig_count_o  (trig_count),
    .drop_count_o  (drop_count),
    .overflow_o    (overflow)
  );

  typedef struct {
    logic [31:0]  num;
    logic [255:0] meta;
  } rec_t;

  rec_t        sb_q[$];
  rec_t        mon_rec;
  logic [31:0] tc_model = 32'd0;
  int          n_assert = 0;
  int          n_fail   = 0;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one trigger; the expected record is queued only if the FIFO
  // (capacity 16) was not full at the capture edge.
  task automatic do_trig(input logic [63:0] t0, input logic [63:0] t1,
                         input logic [63:0] t2, input logic [63:0] t3);
    bit   full;
    rec_t r;
    full = (sb_q.size() >= 16);
    trig = 1'b1;
    tio0 = t0; tio1 = t1; tio2 = t2; tio3 = t3;
    step();
    trig = 1'b0;
    if (!full) begin
      r.num  = tc_model;
      r.meta = {t3, t2, t1, t0};
      sb_q.push_back(r);
    end
    $display("trig num=%0d stored=%0d queued=%0d", tc_model, !full, sb_q.size());
    tc_model++;
  endtask

  task automatic do_trig_rand();
    do_trig({$urandom, $urandom}, {$urandom, $urandom},
            {$urandom, $urandom}, {$urandom, $urandom});
  endtask

  // Monitor: valid must track the scoreboard; accepted records are compared.
  always @(negedge clk) begin
    check_eq("valid_vs_sb", 256'(m_if.m_valid_o), 256'(sb_q.size() != 0));
    if (m_if.m_valid_o && m_if.m_ready_i && sb_q.size() != 0) begin
      mon_rec = sb_q.pop_front();
      check_eq("rec_num", 256'(m_if.m_trig_num_o), 256'(mon_rec.num));
      check_eq("rec_meta", m_if.m_meta_o, mon_rec.meta);
      $display("pop num=%0d exp=%0d", m_if.m_trig_num_o, mon_rec.num);
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0; ce = 1'b1; trig = 1'b0; clear = 1'b0;
    tio0 = '0; tio1 = '0; tio2 = '0; tio3 = '0;
    hlen = 16'd3;
    m_if.m_ready_i = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // Reset state
    check_eq("rst_valid", 256'(m_if.m_valid_o), 256'(0));
    check_eq("rst_holdoff", 256'(holdoff), 256'(0));
    check_eq("rst_trig_count", 256'(trig_count), 256'(0));
    check_eq("rst_drop_count", 256'(drop_count), 256'(0));
    check_eq("rst_overflow", 256'(overflow), 256'(0));

    // Single trigger, holdoff length 3
    m_if.m_ready_i = 1'b1;
    do_trig(64'hAAAA_AAAA_AAAA_AAAA, 64'hBBBB_BBBB_BBBB_BBBB,
            64'hCCCC_CCCC_CCCC_CCCC, 64'hDDDD_DDDD_DDDD_DDDD);
    check_eq("ho3_c0", 256'(holdoff), 256'(1));
    step(); check_eq("ho3_c1", 256'(holdoff), 256'(1));
    step(); check_eq("ho3_c2", 256'(holdoff), 256'(1));
    step(); check_eq("ho3_end", 256'(holdoff), 256'(0));
    check_eq("trig_count_1", 256'(trig_count), 256'(1));

    // Retrigger during HOLD extends holdoff to 5 ce cycles after the second
    hlen = 16'd5;
    do_trig_rand();
    step(); step();
    do_trig_rand();
    for (int i = 0; i < 5; i++) begin
      check_eq("ho_retrig", 256'(holdoff), 256'(1));
      step();
    end
    check_eq("ho_retrig_end", 256'(holdoff), 256'(0));

    // Zero length gives exactly one ce cycle
    hlen = 16'd0;
    do_trig_rand();
    check_eq("ho0_c0", 256'(holdoff), 256'(1));
    step();
    check_eq("ho0_end", 256'(holdoff), 256'(0));

    // Counting only advances on ce
    hlen = 16'd2;
    ce = 1'b0;
    do_trig_rand();
    for (int i = 0; i < 3; i++) begin
      check_eq("ho_ce_stall", 256'(holdoff), 256'(1));
      step();
    end
    ce = 1'b1;
    step(); check_eq("ho_ce_last", 256'(holdoff), 256'(1));
    step(); check_eq("ho_ce_end", 256'(holdoff), 256'(0));

    // Fill with ready low: 18 triggers, 16 stored, almost-full holdoff
    m_if.m_ready_i = 1'b0;
    hlen = 16'd1;
    clear = 1'b1; step(); clear = 1'b0;
    tc_model = 32'd0;
    check_eq("clr_trig_count", 256'(trig_count), 256'(0));
    check_eq("clr_drop_count", 256'(drop_count), 256'(0));
    for (int i = 0; i < 18; i++) begin
      do_trig_rand();
      step();
      check_eq("afull_ho", 256'(holdoff), 256'((i + 1) >= 14));
    end
    check_eq("fill_trig_count", 256'(trig_count), 256'(18));
    check_eq("fill_drop_count", 256'(drop_count), 256'(2));
    check_eq("fill_overflow", 256'(overflow), 256'(1));

    // Stall: head record stays put while ready is low
    for (int i = 0; i < 10; i++) begin
      check_eq("stall_num", 256'(m_if.m_trig_num_o), 256'(sb_q[0].num));
      check_eq("stall_meta", m_if.m_meta_o, sb_q[0].meta);
      step();
    end
    m_if.m_ready_i = 1'b1;
    step();
    m_if.m_ready_i = 1'b0;
    check_eq("after_pulse_num", 256'(m_if.m_trig_num_o), 256'(1));
    check_eq("after_pulse_ho", 256'(holdoff), 256'(1));

    // Refill, then clear coincident with a dropped trigger
    do_trig_rand();
    trig = 1'b1; clear = 1'b1;
    step();
    trig = 1'b0; clear = 1'b0;
    tc_model = 32'd1;
    check_eq("clr_trig_trig_count", 256'(trig_count), 256'(1));
    check_eq("clr_trig_drop_count", 256'(drop_count), 256'(0));

    // Drain in order
    m_if.m_ready_i = 1'b1;
    n = 0;
    while (sb_q.size() != 0 && n < 40) begin
      step();
      n++;
    end
    check_eq("drain_done", 256'(sb_q.size()), 256'(0));
    step();
    check_eq("drained_ho", 256'(holdoff), 256'(0));

    // Asynchronous reset mid-drain
    m_if.m_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) do_trig_rand();
    m_if.m_ready_i = 1'b1;
    step(); step();
    rst_n = 1'b0;
    sb_q.delete();
    tc_model = 32'd0;
    #1;
    check_eq("arst_valid", 256'(m_if.m_valid_o), 256'(0));
    check_eq("arst_holdoff", 256'(holdoff), 256'(0));
    check_eq("arst_trig_count", 256'(trig_count), 256'(0));
    repeat (2) step();
    rst_n = 1'b1;
    step();
    do_trig_rand();
    n = 0;
    while (sb_q.size() != 0 && n < 10) begin
      step();
      n++;
    end
    check_eq("post_rst_drain", 256'(sb_q.size()), 256'(0));
    check_eq("post_rst_count", 256'(trig_count), 256'(1));

    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
